// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell (two Half_Adder
// instances plus an OR) time-shared over WIDTH cycles per addition.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   start  - request an addition (accepted in IDLE or DONE)
//   a, b   - operands, captured on the accepting edge
//   sum    - registered result of the last completed addition
//   cout   - registered carry-out of the last completed addition
//   busy   - high while bits are being processed
//   done   - one-cycle pulse after sum/cout update
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 most recent sum bits; the final bit
    // joins them directly on the completion edge.
    logic [WIDTH-2:0] r_sh;
    logic [WIDTH-1:0] r_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic ha1_s;
    logic ha1_c;
    logic ha2_s;
    logic ha2_c;
    logic s_bit;
    logic c_bit;

    logic last_bit;
    logic accept;
    logic step;
    logic finish;

    Half_Adder u_ha1 (
        .a (a_sh[0]),
        .b (b_sh[0]),
        .s (ha1_s),
        .c (ha1_c)
    );

    Half_Adder u_ha2 (
        .a (ha1_s),
        .b (carry),
        .s (ha2_s),
        .c (ha2_c)
    );

    assign s_bit = ha2_s;
    assign c_bit = ha1_c | ha2_c;

    assign r_nxt    = {s_bit, r_sh};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_bit ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control strobes
    always_comb begin
        accept = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        unique case (state)
            IDLE:    accept = start;
            DONE:    accept = start;
            RUN: begin
                step   = 1'b1;
                finish = last_bit;
            end
            default: accept = 1'b0;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_sh  <= a;
                b_sh  <= b;
                r_sh  <= '0;
                carry <= 1'b0;
                cnt   <= '0;
                busy  <= 1'b1;
            end else if (step) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                r_sh  <= r_nxt[WIDTH-1:1];
                carry <= c_bit;
                cnt   <= cnt + CNT_W'(1);
                if (finish) begin
                    sum  <= r_nxt;
                    cout <= c_bit;
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// Half adder cell used by the serial datapath.
module Half_Adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: accepted requests push the
// exact sum and its due cycle; a negedge monitor checks outputs.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    typedef struct {
        int         t;
        logic [W:0] r;
    } exp_t;

    logic         clk = 1'b0;
    logic         clk_en = 1'b1;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int   checks = 0;
    int   errors = 0;
    int   ec = 0;
    int   free_at = 0;
    exp_t sb[$];
    logic [W:0] last_r = '0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    // Reference: a request is taken when start is seen and the unit
    // is free; the result appears W cycles later, the unit frees one
    // cycle after that.
    always @(posedge clk) begin
        if (rst_n) begin
            ec++;
            if (start && ec >= free_at) begin
                sb.push_back('{t: ec, r: {1'b0, a} + {1'b0, b}});
                free_at = ec + W + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic eb;
            logic ed;
            exp_t f;
            eb = 1'b0;
            ed = 1'b0;
            if (sb.size() > 0) begin
                f  = sb[0];
                eb = (ec >= f.t) && (ec < f.t + W);
                ed = (ec == f.t + W);
            end
            chk("busy", 32'(busy), 32'(eb));
            chk("done", 32'(done), 32'(ed));
            if (busy && done) chk("busy_done_overlap", 32'd1, 32'd0);
            if (ed) begin
                last_r = f.r;
                void'(sb.pop_front());
            end
            chk("sum", 32'(sum), 32'(last_r[W-1:0]));
            chk("cout", 32'(cout), 32'(last_r[W]));
        end
    end

    task automatic model_clear();
        sb.delete();
        free_at = 0;
        last_r  = '0;
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_sum"}, 32'(sum), 32'd0);
        chk({n, "_cout"}, 32'(cout), 32'd0);
        chk({n, "_busy"}, 32'(busy), 32'd0);
        chk({n, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending %0d want 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        op(8'h35, 8'h4A);
        op(8'hFF, 8'h01);
        op(8'hFF, 8'hFF);

        // Start during RUN must be ignored
        @(negedge clk);
        start = 1'b1;
        a = 8'h10;
        b = 8'h20;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Start held high: back-to-back results
        @(negedge clk);
        start = 1'b1;
        a = 8'h01;
        b = 8'h02;
        repeat (30) @(negedge clk);
        start = 1'b0;
        drain();

        // Asynchronous reset in the middle of an addition
        @(negedge clk);
        start = 1'b1;
        a = 8'h80;
        b = 8'h80;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_zero("midrst");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        op(8'h80, 8'h80);

        // Reset with the clock stopped
        op(8'h35, 8'h4A);
        @(negedge clk);
        clk_en = 1'b0;
        #20;
        rst_n = 1'b0;
        model_clear();
        #3;
        chk_zero("noclk");
        #20;
        rst_n = 1'b1;
        #3;
        chk("noclk_hold_sum", 32'(sum), 32'd0);
        clk_en = 1'b1;
        repeat (3) @(negedge clk);

        // Random traffic
        repeat (400) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a = W'($urandom);
            b = W'($urandom);
        end
        start = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. It time-shares one 1-bit full-adder cell across WIDTH cycles to add two WIDTH-bit operands.
- The cell is built from two Half_Adder instances (ports a, b, s, c) plus an OR on the two carries.
- The controller sequences the cell with shift registers, a carry flip-flop, a bit counter and a start/busy/done handshake.
- It sits between a test/stimulus source and the existing Half_Adder datapath. It is the first clocked consumer of that cell.

Parameters:
- WIDTH, 8, operand and sum width in bits. Legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH+1), bit-counter width. Derived; do not override.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled on rising clk.
- a  input  WIDTH  operand A; captured only on the accepting edge.
- b  input  WIDTH  operand B; captured only on the accepting edge.
- sum  output  WIDTH  registered result; holds the last completed sum.
- cout  output  1  registered carry-out of the last completed addition.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse marking that sum/cout were just updated.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-operation):
  - state=IDLE; sum=0, cout=0, busy=0, done=0.
  - Shift registers, carry FF and counter cleared.
  - The operation in flight is abandoned and no done is generated.
- States:
  - IDLE: waiting.
  - RUN: processing bits.
  - DONE: one-cycle completion, behaves as IDLE for start.
- Accept (edge E0), when state in {IDLE, DONE} and start=1:
  - a_sh<=a, b_sh<=b, carry<=0, cnt<=0, busy<=1, state<=RUN.
- Ignore rule: start while state=RUN is ignored. No queuing, no effect on the operation in flight.
- RUN, each edge Ek for k=1..WIDTH:
  - Bit cell inputs are a_sh[0], b_sh[0], carry.
    - s_bit = a_sh[0]^b_sh[0]^carry.
    - c_bit = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
  - a_sh, b_sh shift right by 1.
  - r_sh shifts right with s_bit entering at MSB.
  - carry<=c_bit, cnt<=cnt+1.
- Completion at edge EWIDTH (cnt==WIDTH-1 before the edge):
  - sum<={s_bit, r_sh[WIDTH-1:1]}, cout<=c_bit.
  - busy<=0, done<=1, state<=DONE.
- DONE, at the next edge:
  - done<=0.
  - If start=1, accept as above (back-to-back); otherwise state<=IDLE.
- Latency: done is high during the cycle after edge E(WIDTH), i.e. WIDTH edges after the accepting edge.
  - Throughput with back-to-back starts is one result per WIDTH+1 cycles.
- sum/cout change only at completion edges (or reset). They are stable at all other times, including throughout RUN.
- Arithmetic: {cout,sum} = a + b modulo 2^(WIDTH+1), i.e. an exact unsigned sum. No signed interpretation.
- a and b may change freely after the accepting edge without affecting the result.
- done and busy are never high in the same cycle.

Test Plan:
- WIDTH=8, a=0x35, b=0x4A, start pulsed 1 cycle -> busy high 8 cycles; done pulses 1 cycle 8 edges after accept; sum=0x7F, cout=0.
- a=0xFF, b=0x01 -> sum=0x00, cout=1 (full carry ripple). Then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Start accepted with a=0x10, b=0x20; at the 3rd RUN edge raise start with a=0xAA, b=0x55 -> ignored; result sum=0x30, cout=0; exactly one done pulse.
- Start held high continuously with a=0x01, b=0x02 -> results every 9 cycles; done pulses each separated by 8 busy cycles; sum=0x03 each time; busy never overlaps done.
- Deassert rst_n at 4th RUN edge of 0x80+0x80 -> sum=0, cout=0, busy=0, done=0 immediately (asynchronous); no done after release. New start with 0x80+0x80 -> sum=0x00, cout=1.
- Reset with no clock running -> outputs go to 0 without a clock edge. Previous result 0x7F is cleared to 0 and stays 0 until the next completion.
